src_control_unit: RTL and testbench

Hardwired Moore/Mealy controller that sequences the Mini SRC `datapath` through fetch, decode and execute. It replaces the hand-driven per-cycle control signals used in datapath benches. It drives every datapath control port from a single state register and takes only the instruction register and the branch condition flag back from the datapath. It supports ld, ldi, st, addi, br, jr, nop and halt.

---
 rtl/src_ctrl_pkg.sv | 62 ++++++
 rtl/src_ctrl_decode.sv | 47 ++++
 rtl/src_control_unit.sv | 131 +++++++++++++
 tb/tb_src_control_unit.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/src_ctrl_pkg.sv
// rtl/src_ctrl_pkg.sv - shared state, opcode, bus and ALU encodings for the Mini SRC controller
package src_ctrl_pkg;

  typedef enum logic [4:0] {
    S_IDLE, S_F0, S_F1, S_F2, S_F3, S_DEC,
    S_A3, S_A4, S_A5,
    S_L5, S_L6, S_L7, S_L8,
    S_S6, S_S7,
    S_B3, S_B4, S_B5, S_B6,
    S_J3, S_HALT
  } state_e;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_BR   = 5'b10010;
  localparam logic [4:0] OP_JR   = 5'b10011;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam logic [4:0] BUS_NONE = 5'b00000;
  localparam logic [4:0] BUS_GPR  = 5'b00001;
  localparam logic [4:0] BUS_ZLO  = 5'b10011;
  localparam logic [4:0] BUS_PC   = 5'b10100;
  localparam logic [4:0] BUS_MDR  = 5'b10101;
  localparam logic [4:0] BUS_C    = 5'b11000;

  localparam logic [3:0] ALU_NONE = 4'b0000;
  localparam logic [3:0] ALU_ADD  = 4'b0011;

  typedef struct packed {
    logic       inc_pc;
    logic       e_pc;
    logic       e_ir;
    logic       e_y;
    logic       e_z;
    logic       e_hi;
    logic       e_lo;
    logic       e_mdr;
    logic       e_mar;
    logic       e_gp;
    logic       e_outport;
    logic       e_inport;
    logic       e_ra;
    logic       e_con_ff;
    logic       ram_read;
    logic       ram_write;
    logic       mdr_read;
    logic [3:0] alu_op;
    logic [4:0] bus_sel;
    logic       gra;
    logic       grb;
    logic       grc;
    logic       e_rin;
    logic       e_rout;
    logic       ba_out;
    logic       imm_sel;
    logic       halted;
  } ctrl_t;

endpackage

// File: rtl/src_ctrl_decode.sv
// rtl/src_ctrl_decode.sv - combinational map from controller state (plus CON) to datapath controls
module src_ctrl_decode
  import src_ctrl_pkg::*;
(
  input  state_e state_i,
  input  logic   con_i,
  output ctrl_t  ctrl_o
);

  // Every control defaults low; each state raises only what it needs.
  always_comb begin
    ctrl_o = '0;
    case (state_i)
      S_F0: begin ctrl_o.bus_sel = BUS_PC; ctrl_o.e_mar = 1'b1; ctrl_o.inc_pc = 1'b1; end
      S_F1: begin ctrl_o.ram_read = 1'b1; end
      S_F2: begin ctrl_o.mdr_read = 1'b1; ctrl_o.e_mdr = 1'b1; end
      S_F3: begin ctrl_o.bus_sel = BUS_MDR; ctrl_o.e_ir = 1'b1; end
      S_A3: begin
        ctrl_o.grb = 1'b1; ctrl_o.ba_out = 1'b1; ctrl_o.e_rout = 1'b1;
        ctrl_o.bus_sel = BUS_GPR; ctrl_o.e_y = 1'b1;
      end
      S_A4, S_B5: begin ctrl_o.imm_sel = 1'b1; ctrl_o.alu_op = ALU_ADD; ctrl_o.e_z = 1'b1; end
      S_A5: begin ctrl_o.gra = 1'b1; ctrl_o.e_rin = 1'b1; ctrl_o.bus_sel = BUS_ZLO; end
      S_L5: begin ctrl_o.bus_sel = BUS_ZLO; ctrl_o.e_mar = 1'b1; end
      S_L6: begin ctrl_o.ram_read = 1'b1; end
      S_L7: begin ctrl_o.mdr_read = 1'b1; ctrl_o.e_mdr = 1'b1; end
      S_L8: begin ctrl_o.bus_sel = BUS_MDR; ctrl_o.gra = 1'b1; ctrl_o.e_rin = 1'b1; end
      // MDR takes the bus here because mdr_read stays low.
      S_S6: begin
        ctrl_o.gra = 1'b1; ctrl_o.e_rout = 1'b1; ctrl_o.bus_sel = BUS_GPR; ctrl_o.e_mdr = 1'b1;
      end
      S_S7: begin ctrl_o.ram_write = 1'b1; end
      S_B3: begin
        ctrl_o.gra = 1'b1; ctrl_o.e_rout = 1'b1; ctrl_o.bus_sel = BUS_GPR; ctrl_o.e_con_ff = 1'b1;
      end
      S_B4: begin ctrl_o.bus_sel = BUS_PC; ctrl_o.e_y = 1'b1; end
      // The branch target is always on the bus; CON decides whether PC takes it.
      S_B6: begin ctrl_o.bus_sel = BUS_ZLO; ctrl_o.e_pc = con_i; end
      S_J3: begin
        ctrl_o.gra = 1'b1; ctrl_o.e_rout = 1'b1; ctrl_o.bus_sel = BUS_GPR; ctrl_o.e_pc = 1'b1;
      end
      S_HALT: begin ctrl_o.halted = 1'b1; end
      default: ;
    endcase
  end

endmodule

// File: rtl/src_control_unit.sv
// rtl/src_control_unit.sv - hardwired fetch/decode/execute sequencer for the Mini SRC datapath
module src_control_unit
  import src_ctrl_pkg::*;
(
  input  logic        clock,
  input  logic        clear,
  input  logic        run,
  input  logic [31:0] IR,
  input  logic        CON,
  output logic        incPC,
  output logic        e_PC,
  output logic        e_IR,
  output logic        e_Y,
  output logic        e_Z,
  output logic        e_HI,
  output logic        e_LO,
  output logic        e_MDR,
  output logic        e_MAR,
  output logic        e_GP,
  output logic        e_OutPort,
  output logic        e_InPort,
  output logic        e_RA,
  output logic        e_CON_FF,
  output logic        ram_read,
  output logic        ram_write,
  output logic        MDR_read,
  output logic [3:0]  ALU_op,
  output logic [4:0]  BusDataSelect,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        e_Rin,
  output logic        e_Rout,
  output logic        BAout,
  output logic        imm_sel,
  output logic        halted
);

  state_e     state_q, state_d;
  logic [4:0] op_q;
  logic [4:0] ir_op;
  ctrl_t      ctrl;
  logic       unused_ir_fields;

  assign ir_op            = IR[31:27];
  assign unused_ir_fields = ^IR[26:0];

  // State register; the opcode is captured in DEC so later execute steps
  // do not depend on IR staying stable.
  always_ff @(posedge clock) begin
    if (clear) begin
      state_q <= S_IDLE;
      op_q    <= OP_NOP;
    end else begin
      state_q <= state_d;
      if (state_q == S_DEC) op_q <= ir_op;
    end
  end

  // Next-state sequencing; ld and st share A3/A4/L5 and split on the latched opcode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (run) state_d = S_F0;
      S_F0:   state_d = S_F1;
      S_F1:   state_d = S_F2;
      S_F2:   state_d = S_F3;
      S_F3:   state_d = S_DEC;
      S_DEC: begin
        case (ir_op)
          OP_LD, OP_ST, OP_LDI, OP_ADDI: state_d = S_A3;
          OP_BR:                         state_d = S_B3;
          OP_JR:                         state_d = S_J3;
          OP_HALT:                       state_d = S_HALT;
          default:                       state_d = S_F0;
        endcase
      end
      S_A3:   state_d = S_A4;
      S_A4:   state_d = (op_q == OP_LD || op_q == OP_ST) ? S_L5 : S_A5;
      S_A5:   state_d = S_F0;
      S_L5:   state_d = (op_q == OP_ST) ? S_S6 : S_L6;
      S_L6:   state_d = S_L7;
      S_L7:   state_d = S_L8;
      S_L8:   state_d = S_F0;
      S_S6:   state_d = S_S7;
      S_S7:   state_d = S_F0;
      S_B3:   state_d = S_B4;
      S_B4:   state_d = S_B5;
      S_B5:   state_d = S_B6;
      S_B6:   state_d = S_F0;
      S_J3:   state_d = S_F0;
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  src_ctrl_decode u_decode (
    .state_i (state_q),
    .con_i   (CON),
    .ctrl_o  (ctrl)
  );

  assign incPC         = ctrl.inc_pc;
  assign e_PC          = ctrl.e_pc;
  assign e_IR          = ctrl.e_ir;
  assign e_Y           = ctrl.e_y;
  assign e_Z           = ctrl.e_z;
  assign e_HI          = ctrl.e_hi;
  assign e_LO          = ctrl.e_lo;
  assign e_MDR         = ctrl.e_mdr;
  assign e_MAR         = ctrl.e_mar;
  assign e_GP          = ctrl.e_gp;
  assign e_OutPort     = ctrl.e_outport;
  assign e_InPort      = ctrl.e_inport;
  assign e_RA          = ctrl.e_ra;
  assign e_CON_FF      = ctrl.e_con_ff;
  assign ram_read      = ctrl.ram_read;
  assign ram_write     = ctrl.ram_write;
  assign MDR_read      = ctrl.mdr_read;
  assign ALU_op        = ctrl.alu_op;
  assign BusDataSelect = ctrl.bus_sel;
  assign Gra           = ctrl.gra;
  assign Grb           = ctrl.grb;
  assign Grc           = ctrl.grc;
  assign e_Rin         = ctrl.e_rin;
  assign e_Rout        = ctrl.e_rout;
  assign BAout         = ctrl.ba_out;
  assign imm_sel       = ctrl.imm_sel;
  assign halted        = ctrl.halted;

endmodule

// File: tb/tb_src_control_unit.sv
// tb/tb_src_control_unit.sv - directed trace checks for the Mini SRC control unit
module tb_src_control_unit;

  logic        clock = 1'b0;
  logic        clear, run, CON;
  logic [31:0] IR;
  logic        incPC, e_PC, e_IR, e_Y, e_Z, e_HI, e_LO, e_MDR, e_MAR, e_GP;
  logic        e_OutPort, e_InPort, e_RA, e_CON_FF, ram_read, ram_write, MDR_read;
  logic [3:0]  ALU_op;
  logic [4:0]  BusDataSelect;
  logic        Gra, Grb, Grc, e_Rin, e_Rout, BAout, imm_sel, halted;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  src_control_unit dut (
    .clock(clock), .clear(clear), .run(run), .IR(IR), .CON(CON),
    .incPC(incPC), .e_PC(e_PC), .e_IR(e_IR), .e_Y(e_Y), .e_Z(e_Z), .e_HI(e_HI),
    .e_LO(e_LO), .e_MDR(e_MDR), .e_MAR(e_MAR), .e_GP(e_GP), .e_OutPort(e_OutPort),
    .e_InPort(e_InPort), .e_RA(e_RA), .e_CON_FF(e_CON_FF), .ram_read(ram_read),
    .ram_write(ram_write), .MDR_read(MDR_read), .ALU_op(ALU_op),
    .BusDataSelect(BusDataSelect), .Gra(Gra), .Grb(Grb), .Grc(Grc), .e_Rin(e_Rin),
    .e_Rout(e_Rout), .BAout(BAout), .imm_sel(imm_sel), .halted(halted)
  );

  // All outputs flattened into one word: bit 33 incPC ... bit 0 halted.
  logic [33:0] obs;
  assign obs = {incPC, e_PC, e_IR, e_Y, e_Z, e_HI, e_LO, e_MDR, e_MAR, e_GP,
                e_OutPort, e_InPort, e_RA, e_CON_FF, ram_read, ram_write, MDR_read,
                ALU_op, BusDataSelect, Gra, Grb, Grc, e_Rin, e_Rout, BAout, imm_sel, halted};

  localparam logic [33:0] ONE      = 34'd1;
  localparam logic [33:0] M_INCPC  = ONE << 33;
  localparam logic [33:0] M_EPC    = ONE << 32;
  localparam logic [33:0] M_EIR    = ONE << 31;
  localparam logic [33:0] M_EY     = ONE << 30;
  localparam logic [33:0] M_EZ     = ONE << 29;
  localparam logic [33:0] M_EMDR   = ONE << 26;
  localparam logic [33:0] M_EMAR   = ONE << 25;
  localparam logic [33:0] M_ECON   = ONE << 20;
  localparam logic [33:0] M_RRD    = ONE << 19;
  localparam logic [33:0] M_RWR    = ONE << 18;
  localparam logic [33:0] M_MDRRD  = ONE << 17;
  localparam logic [33:0] M_ADD    = 34'd3 << 13;
  localparam logic [33:0] M_GPR    = 34'h01 << 8;
  localparam logic [33:0] M_ZLO    = 34'h13 << 8;
  localparam logic [33:0] M_PC     = 34'h14 << 8;
  localparam logic [33:0] M_MDR    = 34'h15 << 8;
  localparam logic [33:0] M_GRA    = ONE << 7;
  localparam logic [33:0] M_GRB    = ONE << 6;
  localparam logic [33:0] M_RIN    = ONE << 4;
  localparam logic [33:0] M_ROUT   = ONE << 3;
  localparam logic [33:0] M_BAOUT  = ONE << 2;
  localparam logic [33:0] M_IMM    = ONE << 1;
  localparam logic [33:0] M_HALTED = ONE;

  localparam logic [33:0] X_ZERO = '0;
  localparam logic [33:0] X_F0   = M_PC | M_EMAR | M_INCPC;
  localparam logic [33:0] X_F1   = M_RRD;
  localparam logic [33:0] X_F2   = M_MDRRD | M_EMDR;
  localparam logic [33:0] X_F3   = M_MDR | M_EIR;
  localparam logic [33:0] X_A3   = M_GRB | M_BAOUT | M_ROUT | M_GPR | M_EY;
  localparam logic [33:0] X_A4   = M_IMM | M_ADD | M_EZ;
  localparam logic [33:0] X_A5   = M_GRA | M_RIN | M_ZLO;
  localparam logic [33:0] X_L5   = M_ZLO | M_EMAR;
  localparam logic [33:0] X_L8   = M_MDR | M_GRA | M_RIN;
  localparam logic [33:0] X_S6   = M_GRA | M_ROUT | M_GPR | M_EMDR;
  localparam logic [33:0] X_B3   = M_GRA | M_ROUT | M_GPR | M_ECON;
  localparam logic [33:0] X_B4   = M_PC | M_EY;
  localparam logic [33:0] X_J3   = M_GRA | M_ROUT | M_GPR | M_EPC;

  logic [33:0] trace [0:10];

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [33:0] expected);
    checks++;
    assert (obs === expected) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, expected);
    end
  endtask

  task automatic set_fetch();
    trace[0] = X_F0; trace[1] = X_F1; trace[2] = X_F2; trace[3] = X_F3; trace[4] = X_ZERO;
  endtask

  // Precondition: DUT is in F0. Checks n cycles of the trace, leaving the DUT one state later.
  task automatic do_instr(input string name, input logic [31:0] ir, input logic con, input int n);
    IR  = ir;
    CON = con;
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_c%0d", name, i), trace[i]);
      step();
    end
  endtask

  initial begin
    clear = 1'b1; run = 1'b1; IR = 32'h0; CON = 1'b0;

    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("reset_%0d", i), X_ZERO);
    end
    clear = 1'b0;
    step();
    check("run_to_f0", X_F0);

    set_fetch(); trace[5] = X_A3; trace[6] = X_A4; trace[7] = X_A5;
    do_instr("ldi", 32'h09000078, 1'b0, 8);
    do_instr("addi", 32'h61100005, 1'b0, 8);

    set_fetch(); trace[5] = X_A3; trace[6] = X_A4; trace[7] = X_L5;
    trace[8] = M_RRD; trace[9] = M_MDRRD | M_EMDR; trace[10] = X_L8;
    do_instr("ld", 32'h03100063, 1'b0, 11);

    set_fetch(); trace[5] = X_A3; trace[6] = X_A4; trace[7] = X_L5;
    trace[8] = X_S6; trace[9] = M_RWR;
    do_instr("st", 32'h13100010, 1'b0, 10);

    set_fetch(); trace[5] = X_B3; trace[6] = X_B4; trace[7] = X_A4;
    trace[8] = M_ZLO | M_EPC;
    do_instr("br_taken", 32'h90800005, 1'b1, 9);
    trace[8] = M_ZLO;
    do_instr("br_not", 32'h90800005, 1'b0, 9);

    set_fetch(); trace[5] = X_J3;
    do_instr("jr", 32'h99000000, 1'b0, 6);

    set_fetch();
    do_instr("nop", 32'hD0000000, 1'b0, 5);
    do_instr("illegal", 32'hF8000000, 1'b0, 5);

    // Abort an ld while ram_read is high in L6.
    set_fetch(); trace[5] = X_A3; trace[6] = X_A4; trace[7] = X_L5; trace[8] = M_RRD;
    IR = 32'h03100063;
    for (int i = 0; i < 9; i++) begin
      check($sformatf("abort_ld_c%0d", i), trace[i]);
      if (i < 8) step();
    end
    clear = 1'b1;
    step();
    check("abort_zero", X_ZERO);
    clear = 1'b0; run = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("abort_idle_%0d", i), X_ZERO);
    end

    run = 1'b1;
    step();
    set_fetch();
    do_instr("halt_fetch", 32'hD8000000, 1'b0, 5);
    for (int i = 0; i < 20; i++) begin
      run = i[0];
      check($sformatf("halt_%0d", i), M_HALTED);
      step();
    end
    clear = 1'b1; run = 1'b1;
    step();
    check("halt_clear", X_ZERO);
    clear = 1'b0; run = 1'b0;
    step();
    check("halt_idle", X_ZERO);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
